fetch_unit: RTL and testbench

- Instruction-fetch stage of the RV32I core, directly upstream of the opcode type decoder.
- Owns the PC register and runs a small request/response handshake with instruction memory.
- Holds the fetched instruction stable while the core is stalled.
- Drives `opcode` to the type decoder; `opcode` is forced to zero when no valid instruction is present, so the decoder outputs all-zero flags.

---
 rtl/rv32i_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit_next_pc_sel.sv | 17 +
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I core types and constants
package rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  localparam int          OPCODE_W  = 7;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Major opcodes, shared with the opcode type decoder
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'h03;
  localparam logic [OPCODE_W-1:0] OP_FENCE  = 7'h0F;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'h13;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'h17;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'h23;
  localparam logic [OPCODE_W-1:0] OP_REG    = 7'h33;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'h37;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'h63;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'h67;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'h6F;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'h73;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );

endinterface

// File: rtl/fetch_unit_next_pc_sel.sv
// rtl/fetch_unit_next_pc_sel.sv - next PC mux and redirect alignment check
module next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            target_misaligned
);

  assign pc_plus4          = pc + XLEN'(4);
  assign next_pc           = redirect ? redirect_pc : pc_plus4;
  assign target_misaligned = redirect && (redirect_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC register, imem handshake, held instruction
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic [31:0]         fetch_count,
  output logic                misaligned
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            instr_valid_q;
  logic            req_q;
  logic [31:0]     fetch_count_q;
  logic            misaligned_q;

  logic [XLEN-1:0] next_pc;
  logic            target_misaligned;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc                (pc_q),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .pc_plus4          (pc_plus4),
    .next_pc           (next_pc),
    .target_misaligned (target_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      req_q         <= 1'b0;
      fetch_count_q <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_q   <= 1'b1;
          state_q <= FETCH;
        end
        FETCH: begin
          if (imem.imem_valid) begin
            instr_q       <= imem.imem_rdata;
            instr_valid_q <= 1'b1;
            req_q         <= 1'b0;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          // stall wins over redirect so the held instruction never retires early
          if (!stall) begin
            instr_valid_q <= 1'b0;
            if (target_misaligned) begin
              misaligned_q <= 1'b1;
              state_q      <= HALT;
            end else begin
              pc_q          <= next_pc;
              fetch_count_q <= fetch_count_q + 32'd1;
              req_q         <= 1'b1;
              state_q       <= FETCH;
            end
          end
        end
        HALT: begin
        end
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign opcode         = instr_valid_q ? instr_q[OPCODE_W-1:0] : '0;
  assign fetch_count    = fetch_count_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic [6:0]  opcode;
  logic [31:0] fetch_count;
  logic        misaligned;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .fetch_count (fetch_count),
    .misaligned  (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    case (a[4:2])
      3'd0:    op = 7'h33;
      3'd1:    op = 7'h13;
      3'd2:    op = 7'h03;
      3'd3:    op = 7'h23;
      3'd4:    op = 7'h63;
      3'd5:    op = 7'h6F;
      3'd6:    op = 7'h37;
      default: op = 7'h17;
    endcase
    return {a[26:2], op};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;

  typedef struct {
    int          wait_c;
    int          stall_c;
    bit          redir;
    logic [31:0] rpc;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[8];
  int          vectors;
  int          miscompares;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_instr"}, instr, 32'h0000_0013);
    check({tag, "_ivalid"}, 32'(instr_valid), 32'd0);
    check({tag, "_opcode"}, 32'(opcode), 32'd0);
    check({tag, "_count"}, fetch_count, 32'd0);
    check({tag, "_misal"}, 32'(misaligned), 32'd0);
  endtask

  // Precondition: at a negedge with the DUT in FETCH; leaves it in HOLD
  task automatic fetch_one(input int wait_c);
    sb_t e;
    check("fetch_req", 32'(bus.imem_req), 32'd1);
    check("fetch_addr", bus.imem_addr, exp_pc);
    for (int w = 0; w < wait_c; w++) begin
      bus.imem_valid = 1'b0;
      @(negedge clk);
      check("wait_req", 32'(bus.imem_req), 32'd1);
      check("wait_addr", bus.imem_addr, exp_pc);
      check("wait_ivalid", 32'(instr_valid), 32'd0);
      check("wait_opcode", 32'(opcode), 32'd0);
    end
    bus.imem_valid = 1'b1;
    sb_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
    @(negedge clk);
    bus.imem_valid = 1'b0;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("hold_instr", instr, e.instr);
      check("hold_pc", pc, e.pc);
      check("hold_opcode", 32'(opcode), 32'(e.instr[6:0]));
      check("hold_ivalid", 32'(instr_valid), 32'd1);
      check("hold_req", 32'(bus.imem_req), 32'd0);
      check("hold_pc4", pc_plus4, e.pc + 32'd4);
    end
  endtask

  // Precondition: in HOLD; stalls with a decoy redirect then leaves HOLD
  task automatic retire(input int stall_c, input bit redir, input logic [31:0] rpc);
    logic [31:0] held;
    held = instr;
    for (int s = 0; s < stall_c; s++) begin
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      @(negedge clk);
      check("stall_pc", pc, exp_pc);
      check("stall_instr", instr, held);
      check("stall_ivalid", 32'(instr_valid), 32'd1);
      check("stall_count", fetch_count, exp_count);
    end
    stall       = 1'b0;
    redirect    = redir;
    redirect_pc = rpc;
    @(negedge clk);
    redirect  = 1'b0;
    exp_pc    = redir ? rpc : exp_pc + 32'd4;
    exp_count = exp_count + 32'd1;
    check("adv_pc", pc, exp_pc);
    check("adv_count", fetch_count, exp_count);
    check("adv_ivalid", 32'(instr_valid), 32'd0);
    check("adv_opcode", 32'(opcode), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    vecs[0] = '{wait_c: 0, stall_c: 0, redir: 1'b0, rpc: 32'h0};
    vecs[1] = '{wait_c: 0, stall_c: 5, redir: 1'b0, rpc: 32'h0};
    vecs[2] = '{wait_c: 0, stall_c: 0, redir: 1'b1, rpc: 32'h0000_0100};
    vecs[3] = '{wait_c: 3, stall_c: 0, redir: 1'b0, rpc: 32'h0};
    vecs[4] = '{wait_c: 1, stall_c: 2, redir: 1'b1, rpc: 32'hFFFF_FFFC};
    vecs[5] = '{wait_c: 0, stall_c: 0, redir: 1'b0, rpc: 32'h0};
    vecs[6] = '{wait_c: 2, stall_c: 1, redir: 1'b1, rpc: 32'h0000_0040};
    vecs[7] = '{wait_c: 0, stall_c: 0, redir: 1'b0, rpc: 32'h0};

    rst_n          = 1'b1;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_pc    = 32'h0;
    bus.imem_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc    = 32'h0;
    exp_count = 32'h0;
    check("post_rst_req", 32'(bus.imem_req), 32'd1);

    for (int i = 0; i < 8; i++) begin
      fetch_one(vecs[i].wait_c);
      retire(vecs[i].stall_c, vecs[i].redir, vecs[i].rpc);
    end

    // Misaligned redirect halts the stage until reset
    fetch_one(0);
    stall       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect = 1'b0;
    for (int h = 0; h < 4; h++) begin
      bus.imem_valid = h[0];
      check("halt_misal", 32'(misaligned), 32'd1);
      check("halt_req", 32'(bus.imem_req), 32'd0);
      check("halt_opcode", 32'(opcode), 32'd0);
      check("halt_ivalid", 32'(instr_valid), 32'd0);
      check("halt_pc", pc, exp_pc);
      check("halt_count", fetch_count, exp_count);
      @(negedge clk);
    end
    bus.imem_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("halt_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc    = 32'h0;
    exp_count = 32'h0;
    check("rst2_req", 32'(bus.imem_req), 32'd1);

    // Asynchronous reset while a fetch is outstanding
    fetch_one(0);
    retire(0, 1'b0, 32'h0);
    bus.imem_valid = 1'b0;
    @(negedge clk);
    check("midf_req", 32'(bus.imem_req), 32'd1);
    check("midf_pc", pc, 32'h4);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midf_rst");
    bus.imem_valid = 1'b1;
    @(negedge clk);
    check_reset_outputs("midf_held");
    bus.imem_valid = 1'b0;
    rst_n          = 1'b1;
    @(negedge clk);
    check("late_req", 32'(bus.imem_req), 32'd1);
    check("late_instr", instr, 32'h0000_0013);
    check("late_ivalid", 32'(instr_valid), 32'd0);
    check("late_pc", pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
